draw_rect_ctl: RTL
==================

Name: draw_rect_ctl

Overview:
- Position controller upstream of the rectangle-drawing stage; produces the `xpos`/`ypos` that stage consumes.
- Follows the mouse until the left button is clicked.
- After a click, drops the rectangle under gravity with damped bounces off the screen bottom, then rests.
- A second click returns it to mouse-follow.
- Motion updates run on a fixed tick derived from the pixel clock.

Parameters:
- TICK_DIV, 650_000, clock cycles per motion step (100 Hz at 65 MHz).
- SCREEN_H, 768, visible lines.
- REC_H, 64, rectangle height in lines.
- G, 1, velocity increment/decrement per tick (lines/tick).
- VMAX, 64, velocity saturation value.
- LOSS_SHIFT, 1, bounce damping: new_vel = vel - (vel >> LOSS_SHIFT).
- MIN_VEL, 2, post-bounce velocity below which the rectangle rests.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- mouse_left  in  1  left button level, already synchronous to clk.
- mouse_xpos  in  12  mouse x.
- mouse_ypos  in  12  mouse y.
- xpos  out  12  rectangle top-left x, registered.
- ypos  out  12  rectangle top-left y, registered.
- moving  out  1  high in FALL or RISE.

Behaviour:
- Reset (synchronous):
  - State FOLLOW.
  - xpos=0, ypos=0, moving=0.
  - vel=0, tick counter=0.
  - Button history register = 1, so a button held through reset release gives no edge.
- Tick: free-running counter 0..TICK_DIV-1. tick=1 in the cycle the counter equals TICK_DIV-1, then the counter wraps to 0. The counter runs in all states.
- click: mouse_left=1 and previous sample=0. The previous sample updates every cycle.
- FOLLOW:
  - Each cycle xpos<=mouse_xpos and ypos<=mouse_ypos (latency 1).
  - On click: go to FALL, vel<=0. Same-cycle load of mouse x/y into xpos/ypos.
- FALL, on tick only:
  - v' = min(vel+G, VMAX); y' = ypos + v'.
  - If y' >= SCREEN_H-REC_H: ypos<=SCREEN_H-REC_H and b = v' - (v' >> LOSS_SHIFT).
    - If b < MIN_VEL: REST, vel<=0.
    - Else: RISE, vel<=b.
  - Else: ypos<=y', vel<=v'.
- RISE, on tick only:
  - If vel > ypos: ypos<=0, vel<=0, go to FALL.
  - Else: ypos<=ypos-vel and vel<=vel-G. If vel <= G: vel<=0, go to FALL.
- REST: hold xpos/ypos. On click go to FOLLOW; xpos/ypos take the mouse position on the next cycle.
- Clicks in FALL/RISE are ignored.
- xpos is constant outside FOLLOW.
- moving is registered and equals (next state is FALL or RISE).
- Arithmetic: y and vel are computed in 13 bits to avoid wrap. Outputs are 12 bits.
- Click at ypos already ≥ SCREEN_H-REC_H: clamps and bounces/rests on the first tick.
- Tick and click in the same cycle in FOLLOW: the click wins. The tick has no effect there.
- rst asserted mid-motion: next cycle is the full reset state regardless of state or tick phase.

Test Plan:
All scenarios use TICK_DIV=4, SCREEN_H=100, REC_H=10, G=1, LOSS_SHIFT=1, MIN_VEL=2, VMAX=64 unless stated.
- Follow: mouse (30,40) → (31,41) on consecutive cycles → xpos/ypos match one cycle later; moving=0.
- Fall/bounce: click at (20,50) → ypos per tick 51,53,56,60,65,71,78,86, then 90 (clamped) with vel=5 and RISE → then 85,81,78,76,75 → FALL again, vel=0; xpos stays 20 throughout.
- Rest: click at y=88 → tick 1: y'=89 → tick 2: y'=91, clamp to 90, b=1 < 2 → REST, moving=0. A further click → FOLLOW, with xpos/ypos equal to the mouse position next cycle.
- Top clamp: force RISE with ypos=3, vel=5 (VMAX large) → next tick ypos=0, state FALL, vel=0.
- Edge cases:
  - Button held across reset release → no transition.
  - Button held for 20 cycles in FOLLOW → exactly one click.
  - Clicks during FALL → ignored.
- Reset mid-FALL: assert rst for one cycle → xpos=ypos=0, moving=0, FOLLOW. Tick phase restarts, so the first tick is TICK_DIV cycles after reset release.

Source files
------------

// File: rtl/draw_rect_ctl.sv
// Rectangle position controller: follows the mouse, then on a click
// drops under gravity with damped bounces off the bottom and rests.
module draw_rect_ctl #(
  parameter int TICK_DIV   = 650_000,
  parameter int SCREEN_H   = 768,
  parameter int REC_H      = 64,
  parameter int G          = 1,
  parameter int VMAX       = 64,
  parameter int LOSS_SHIFT = 1,
  parameter int MIN_VEL    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        moving
);

  localparam int FLOOR = SCREEN_H - REC_H;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    FOLLOW, FALL, RISE, REST
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          btn_q;
  logic          tick;
  logic          click;
  logic [12:0]   vel;
  logic [12:0]   v_sum;
  logic [12:0]   v_inc;
  logic [12:0]   y_ext;
  logic [12:0]   y_nxt;
  logic [12:0]   bnc;

  assign tick  = (cnt == CW'(TICK_DIV - 1));
  assign click = mouse_left & ~btn_q;

  // 13-bit arithmetic keeps y + v from wrapping past 4095
  always_comb begin
    v_sum = vel + 13'(G);
    v_inc = (v_sum > 13'(VMAX)) ? 13'(VMAX) : v_sum;
    y_ext = {1'b0, ypos};
    y_nxt = y_ext + v_inc;
    bnc   = v_inc - (v_inc >> LOSS_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FOLLOW;
      xpos   <= '0;
      ypos   <= '0;
      moving <= 1'b0;
      vel    <= '0;
      cnt    <= '0;
      btn_q  <= 1'b1;
    end else begin
      btn_q <= mouse_left;
      cnt   <= tick ? '0 : cnt + 1'b1;
      unique case (state)
        FOLLOW: begin
          xpos <= mouse_xpos;
          ypos <= mouse_ypos;
          if (click) begin
            state  <= FALL;
            vel    <= '0;
            moving <= 1'b1;
          end
        end
        FALL: begin
          if (tick) begin
            if (y_nxt >= 13'(FLOOR)) begin
              ypos <= 12'(FLOOR);
              if (bnc < 13'(MIN_VEL)) begin
                state  <= REST;
                vel    <= '0;
                moving <= 1'b0;
              end else begin
                state <= RISE;
                vel   <= bnc;
              end
            end else begin
              ypos <= y_nxt[11:0];
              vel  <= v_inc;
            end
          end
        end
        RISE: begin
          if (tick) begin
            if (vel > y_ext) begin
              ypos  <= '0;
              vel   <= '0;
              state <= FALL;
            end else begin
              ypos <= 12'(y_ext - vel);
              if (vel <= 13'(G)) begin
                vel   <= '0;
                state <= FALL;
              end else begin
                vel <= vel - 13'(G);
              end
            end
          end
        end
        REST: begin
          if (click) state <= FOLLOW;
        end
        default: begin
          state  <= FOLLOW;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule
